cache_fill_fsm: RTL and testbench

Miss-handling responder that sits between the pipeline's cache arrays and the multi-cycle main memory. On a miss it fetches the whole block from memory, streams each returned word into the cache data array, and writes the tag after the last word. It holds `fsm_busy` high for the whole fill so the hazard unit stalls PC, IF/ID and the stage that missed. One instance serves the I-cache and one serves the D-cache.

---
 rtl/cache_fill_fsm_if.sv | 28 ++
 rtl/cache_fill_fsm.sv | 103 ++++++++++
 tb/tb_cache_fill_fsm.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_fsm_if.sv
// Cache-fill bus: miss request from the cache lookup, read requests to and
// returns from main memory, and write strobes into the cache arrays.
// master = fill FSM, slave = surrounding pipeline/memory.
interface cache_fill_fsm_if;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        memory_enable;
  logic [15:0] memory_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] cache_word_addr;
  logic [15:0] cache_write_data;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, memory_enable, memory_address,
           write_data_array, write_tag_array, cache_word_addr, cache_write_data
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, memory_enable, memory_address,
           write_data_array, write_tag_array, cache_word_addr, cache_write_data
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: issues BLOCK_WORDS back-to-back word reads to a
// pipelined memory, writes each returned word into the data array in order,
// and writes the tag together with the final word. BLOCK_WORDS must be a
// power of two between 2 and 16.
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  cache_fill_fsm_if.master  bus
);

  localparam int          CNT_W    = $clog2(BLOCK_WORDS) + 1;
  localparam logic [15:0] OFF_MASK = 16'((2 * BLOCK_WORDS) - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [15:0]      base_q, base_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] recv_cnt_q, recv_cnt_d;

  logic issue_active;
  logic recv_active;
  logic last_word;

  // Request/return qualifiers; returns beyond the block end are dropped
  always_comb begin
    issue_active = (state_q == ST_FILL) && (issue_cnt_q != CNT_FULL);
    recv_active  = (state_q == ST_FILL) && bus.memory_data_valid &&
                   (recv_cnt_q != CNT_FULL);
    last_word    = recv_active && (recv_cnt_q == CNT_LAST);
  end

  // Outputs decoded from registered state plus the memory return strobe
  always_comb begin
    bus.fsm_busy         = (state_q == ST_FILL) || bus.miss_detected;
    bus.memory_enable    = issue_active;
    bus.memory_address   = 16'h0000;
    bus.write_data_array = recv_active;
    bus.write_tag_array  = last_word;
    bus.cache_word_addr  = 16'h0000;
    bus.cache_write_data = 16'h0000;
    if (issue_active) begin
      // Word offset within the block never carries out of the block
      bus.memory_address = base_q + 16'({issue_cnt_q, 1'b0});
    end
    if (recv_active) begin
      bus.cache_word_addr  = base_q + 16'({recv_cnt_q, 1'b0});
      bus.cache_write_data = bus.memory_data;
    end
  end

  // Next-state: accept a miss in IDLE, advance counters during FILL
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.miss_detected) begin
          base_d      = bus.miss_address & ~OFF_MASK;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = ST_FILL;
        end
      end
      default: begin
        if (issue_active) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (recv_active) begin
          recv_cnt_d = recv_cnt_q + 1'b1;
        end
        // Misses presented during the fill are not latched; the requester
        // re-presents after fsm_busy drops
        if (last_word) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State registers with synchronous reset; reset abandons any fill
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= 16'h0000;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: the stimulus process drives directed
// fills and queues expected requests, cache writes and busy values tagged
// with their cycle; the monitor pops and compares on the falling edge.
module tb_cache_fill_fsm;
  localparam int BW = 8;

  typedef struct { int cyc; logic [15:0] addr; } req_t;
  typedef struct { int cyc; logic [15:0] addr; logic [15:0] data; logic tag; } wr_t;
  typedef struct { int cyc; logic busy; } busy_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  req_t  req_q[$];
  wr_t   wr_q[$];
  busy_t busy_q[$];

  int gap_tab[7] = '{2, 0, 3, 1, 0, 2, 3};

  cache_fill_fsm_if bus();

  cache_fill_fsm #(.BLOCK_WORDS(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_busy(input logic b);
    busy_t e;
    e.cyc = cyc; e.busy = b;
    busy_q.push_back(e);
  endtask

  task automatic idle_step();
    step();
    bus.miss_detected = 1'b0;
    bus.miss_address = 16'h0000;
    bus.memory_data_valid = 1'b0;
    bus.memory_data = 16'hDEAD;
    exp_busy(1'b0);
  endtask

  // One fill starting with the miss in relative cycle 0. Returns arrive at
  // latency lat, optionally with the gap table between valids. pa/pb are
  // relative cycles of stray 0x4000 misses; hold keeps the miss asserted.
  task automatic run_fill(input logic [15:0] addr, input int lat, input bit use_gaps,
                          input int pa, input int pb, input bit hold);
    int ret[BW];
    int last;
    logic [15:0] base;
    base = addr & 16'hFFF0;
    ret[0] = 1 + lat;
    for (int k = 1; k < BW; k++) ret[k] = ret[k-1] + 1 + (use_gaps ? gap_tab[k-1] : 0);
    last = ret[BW-1];
    for (int r = 0; r <= last; r++) begin
      step();
      if (r == 0 || hold) begin
        bus.miss_detected = 1'b1; bus.miss_address = addr;
      end else if (r == pa || r == pb) begin
        bus.miss_detected = 1'b1; bus.miss_address = 16'h4000;
      end else begin
        bus.miss_detected = 1'b0; bus.miss_address = 16'h0000;
      end
      bus.memory_data_valid = 1'b0;
      bus.memory_data = 16'hDEAD;
      for (int k = 0; k < BW; k++) begin
        if (ret[k] == r) begin
          wr_t w;
          w.cyc = cyc;
          w.addr = base + 16'(2 * k);
          w.data = w.addr ^ 16'hA5A5;
          w.tag = (k == BW - 1);
          bus.memory_data_valid = 1'b1;
          bus.memory_data = w.data;
          wr_q.push_back(w);
        end
      end
      if (r >= 1 && r <= BW) begin
        req_t q;
        q.cyc = cyc;
        q.addr = base + 16'(2 * (r - 1));
        req_q.push_back(q);
      end
      exp_busy(1'b1);
    end
  endtask

  // Stimulus
  initial begin
    bus.miss_detected = 1'b0;
    bus.miss_address = 16'h0000;
    bus.memory_data_valid = 1'b0;
    bus.memory_data = 16'h0000;
    // Reset held for two edges
    step();
    mon_en = 1'b1;
    exp_busy(1'b0);
    step();
    exp_busy(1'b0);
    rst = 1'b0;
    // Returns while IDLE must not write
    for (int i = 0; i < 2; i++) begin
      step();
      bus.memory_data_valid = 1'b1;
      bus.memory_data = 16'hBEEF;
      exp_busy(1'b0);
    end
    idle_step();

    // Basic fill, latency 4
    run_fill(16'h1236, 4, 1'b0, -1, -1, 1'b0);
    idle_step();
    // Variable return spacing, latency 7
    run_fill(16'h1230, 7, 1'b1, -1, -1, 1'b0);
    idle_step();
    // Stray misses in cycles 3 and 12
    run_fill(16'h1230, 4, 1'b0, 3, 12, 1'b0);
    idle_step();
    // Back-to-back fills at the top of the address space
    run_fill(16'hFFF8, 4, 1'b0, -1, -1, 1'b1);
    run_fill(16'hFFF8, 4, 1'b0, -1, -1, 1'b1);
    idle_step();

    // Reset in cycle 6 of a fill, then late returns in cycles 7..12
    for (int r = 0; r <= 12; r++) begin
      step();
      bus.miss_detected = (r == 0);
      bus.miss_address = (r == 0) ? 16'h1230 : 16'h0000;
      rst = (r == 6);
      bus.memory_data_valid = (r >= 5);
      bus.memory_data = (r >= 5) ? ((16'h1230 + 16'(2 * (r - 5))) ^ 16'hA5A5) : 16'hDEAD;
      if (r == 5 || r == 6) begin
        wr_t w;
        w.cyc = cyc; w.addr = 16'h1230 + 16'(2 * (r - 5));
        w.data = w.addr ^ 16'hA5A5; w.tag = 1'b0;
        wr_q.push_back(w);
      end
      if (r >= 1 && r <= 6) begin
        req_t q;
        q.cyc = cyc; q.addr = 16'h1230 + 16'(2 * (r - 1));
        req_q.push_back(q);
      end
      exp_busy(r <= 6);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) idle_step();
    step();
    done = 1'b1;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    busy_t b;
    req_t  q;
    wr_t   w;
    if (mon_en) begin
      if (busy_q.size() > 0 && busy_q[0].cyc == cyc) begin
        b = busy_q.pop_front();
        checks++;
        if (bus.fsm_busy !== b.busy) begin
          errors++;
          $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.fsm_busy, b.busy);
        end
      end
      checks++;
      if (bus.memory_enable === 1'b1) begin
        if (req_q.size() == 0 || req_q[0].cyc != cyc) begin
          errors++;
          $display("FAIL req_unexpected cyc=%0d got_addr=%h exp=none", cyc, bus.memory_address);
        end else begin
          q = req_q.pop_front();
          if (bus.memory_address !== q.addr) begin
            errors++;
            $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, bus.memory_address, q.addr);
          end
        end
      end else begin
        if (bus.memory_enable !== 1'b0 || bus.memory_address !== 16'h0000) begin
          errors++;
          $display("FAIL req_idle cyc=%0d got_en=%b got_addr=%h exp=0/0000", cyc,
                   bus.memory_enable, bus.memory_address);
        end else if (req_q.size() > 0 && req_q[0].cyc <= cyc) begin
          q = req_q.pop_front();
          errors++;
          $display("FAIL req_missing cyc=%0d got=none exp_addr=%h", cyc, q.addr);
        end
      end
      checks++;
      if (bus.write_data_array === 1'b1) begin
        if (wr_q.size() == 0 || wr_q[0].cyc != cyc) begin
          errors++;
          $display("FAIL wr_unexpected cyc=%0d got_addr=%h got_data=%h exp=none", cyc,
                   bus.cache_word_addr, bus.cache_write_data);
        end else begin
          w = wr_q.pop_front();
          if (bus.cache_word_addr !== w.addr || bus.cache_write_data !== w.data ||
              bus.write_tag_array !== w.tag) begin
            errors++;
            $display("FAIL wr_word cyc=%0d got=%h/%h/tag%b exp=%h/%h/tag%b", cyc,
                     bus.cache_word_addr, bus.cache_write_data, bus.write_tag_array,
                     w.addr, w.data, w.tag);
          end
        end
      end else begin
        if (bus.write_data_array !== 1'b0 || bus.write_tag_array !== 1'b0 ||
            bus.cache_word_addr !== 16'h0000 || bus.cache_write_data !== 16'h0000) begin
          errors++;
          $display("FAIL wr_idle cyc=%0d got=%b/%b/%h/%h exp=0/0/0000/0000", cyc,
                   bus.write_data_array, bus.write_tag_array, bus.cache_word_addr,
                   bus.cache_write_data);
        end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
          w = wr_q.pop_front();
          errors++;
          $display("FAIL wr_missing cyc=%0d got=none exp_addr=%h", cyc, w.addr);
        end
      end
    end
    if (done) begin
      checks++;
      if (req_q.size() + wr_q.size() + busy_q.size() != 0) begin
        errors++;
        $display("FAIL leftover got=%0d/%0d/%0d exp=0/0/0", req_q.size(), wr_q.size(),
                 busy_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  // Overall time bound
  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
